// File: rtl/reg_scoreboard_if.sv
// Decode/issue and writeback signals between the pipeline and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned CW   = 2,
  parameter int unsigned SW   = 8
);
  // Decode side
  logic            IssueValid;
  logic [AW-1:0]   RA;
  logic [AW-1:0]   RB;
  logic [AW-1:0]   RDo;
  logic            DstValid;
  logic [CW-1:0]   Lat;
  logic            Flush;
  // Register file writeback side
  logic            WbRegWrite;
  logic [AW-1:0]   WbRDo;
  // Scoreboard results
  logic            Stall;
  logic            IssueFire;
  logic [NREG-1:0] Busy;
  logic            SbErr;
  logic [SW-1:0]   StallCnt;

  modport master (
    output IssueValid, RA, RB, RDo, DstValid, Lat, Flush, WbRegWrite, WbRDo,
    input  Stall, IssueFire, Busy, SbErr, StallCnt
  );

  modport slave (
    input  IssueValid, RA, RB, RDo, DstValid, Lat, Flush, WbRegWrite, WbRDo,
    output Stall, IssueFire, Busy, SbErr, StallCnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-stage scoreboard for the 8x8 register file: per-register countdown of
// in-flight writes, RAW/WAW issue stall, and writeback timing cross-check.
module reg_scoreboard #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned CW   = 2,
  parameter int unsigned SW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  // R0 and the top register are constants in the register file and never tracked.
  localparam int unsigned RTOP = NREG - 1;

  logic [CW-1:0]   r_cnt [NREG];
  logic            r_sb_err;
  logic [SW-1:0]   r_stall_cnt;

  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_issue_sel;
  logic            w_stall;
  logic            w_fire;
  logic [CW-1:0]   w_lat;
  logic            w_wb_tracked;
  logic            w_wb_err;

  // Pending-write bitmap; untracked registers forced to zero.
  always_comb begin
    w_busy = '0;
    for (int i = 1; i < int'(RTOP); i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  // Hazard detection: RAW on both sources, WAW on destination; no bypass at cnt=1.
  always_comb begin
    w_stall = sb.IssueValid & ~sb.Flush &
              (w_busy[sb.RA] | w_busy[sb.RB] | (sb.DstValid & w_busy[sb.RDo]));
    w_fire  = sb.IssueValid & ~w_stall & ~sb.Flush;
    w_lat   = (sb.Lat == '0) ? CW'(1) : sb.Lat;
  end

  // One-hot select of the register that an accepted instruction will write.
  always_comb begin
    w_issue_sel = '0;
    for (int i = 1; i < int'(RTOP); i++) begin
      w_issue_sel[i] = w_fire & sb.DstValid & (sb.RDo == AW'(i));
    end
  end

  // Writeback must land exactly on the edge where the counter expires (cnt=1).
  always_comb begin
    w_wb_tracked = (sb.WbRDo != '0) && (sb.WbRDo != AW'(RTOP));
    w_wb_err     = sb.WbRegWrite & ~sb.Flush & w_wb_tracked &
                   (r_cnt[sb.WbRDo] != CW'(1));
  end

  // Latency counters: flush clears, issue loads, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (sb.Flush) begin
          r_cnt[i] <= '0;
        end else if (w_issue_sel[i]) begin
          r_cnt[i] <= w_lat;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Sticky writeback-mismatch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if (w_wb_err) begin
      r_sb_err <= 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + SW'(1);
    end
  end

  assign sb.Stall     = w_stall;
  assign sb.IssueFire = w_fire;
  assign sb.Busy      = w_busy;
  assign sb.SbErr     = r_sb_err;
  assign sb.StallCnt  = r_stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reg_scoreboard_if #(.NREG(8), .AW(3), .CW(2), .SW(8)) sbif ();

  reg_scoreboard #(.NREG(8), .AW(3), .CW(2), .SW(8)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_issue(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                             input logic [2:0] rd, input logic dv, input logic [1:0] lat);
    sbif.IssueValid = v;
    sbif.RA         = ra;
    sbif.RB         = rb;
    sbif.RDo        = rd;
    sbif.DstValid   = dv;
    sbif.Lat        = lat;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    sbif.Flush      = 1'b0;
    sbif.WbRegWrite = 1'b0;
    sbif.WbRDo      = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_busy",     32'(sbif.Busy),      32'h00);
    chk("rst_stall",    32'(sbif.Stall),     32'h0);
    chk("rst_fire",     32'(sbif.IssueFire), 32'h0);
    chk("rst_sberr",    32'(sbif.SbErr),     32'h0);
    chk("rst_stallcnt", 32'(sbif.StallCnt),  32'h00);

    // Basic issue to R3 with Lat=2
    drive_issue(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 2'd2);
    #1;
    chk("iss_fire",  32'(sbif.IssueFire), 32'h1);
    chk("iss_stall", 32'(sbif.Stall),     32'h0);
    tick();
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    #1;
    chk("iss_busy1", 32'(sbif.Busy), 32'h08);
    tick();
    // RAW on R3 while cnt=1: still stalls
    drive_issue(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 2'd1);
    #1;
    chk("raw_busy",  32'(sbif.Busy),      32'h08);
    chk("raw_stall", 32'(sbif.Stall),     32'h1);
    chk("raw_fire0", 32'(sbif.IssueFire), 32'h0);
    tick();
    chk("raw_clear", 32'(sbif.Busy),      32'h00);
    chk("raw_go",    32'(sbif.Stall),     32'h0);
    chk("raw_fire1", 32'(sbif.IssueFire), 32'h1);
    chk("raw_cnt",   32'(sbif.StallCnt),  32'h01);
    tick();

    // R0 and R7 never tracked
    drive_issue(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 2'd3);
    #1;
    chk("r0_fire", 32'(sbif.IssueFire), 32'h1);
    tick();
    drive_issue(1'b1, 3'd0, 3'd0, 3'd7, 1'b1, 2'd3);
    #1;
    chk("r7_fire", 32'(sbif.IssueFire), 32'h1);
    tick();
    drive_issue(1'b1, 3'd0, 3'd7, 3'd0, 1'b0, 2'd0);
    sbif.WbRegWrite = 1'b1;
    sbif.WbRDo      = 3'd0;
    #1;
    chk("r07_busy",  32'(sbif.Busy),  32'h00);
    chk("r07_stall", 32'(sbif.Stall), 32'h0);
    tick();
    sbif.WbRDo = 3'd7;
    tick();
    sbif.WbRegWrite = 1'b0;
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    #1;
    chk("r07_sberr", 32'(sbif.SbErr), 32'h0);

    // Lat=0 behaves as Lat=1
    drive_issue(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 2'd0);
    tick();
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    #1;
    chk("lat0_busy", 32'(sbif.Busy), 32'h04);
    tick();
    chk("lat0_free", 32'(sbif.Busy), 32'h00);

    // Writeback at correct edge (cnt=1) leaves SbErr clear
    drive_issue(1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 2'd3);
    tick();
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    tick();
    tick();
    sbif.WbRegWrite = 1'b1;
    sbif.WbRDo      = 3'd5;
    #1;
    chk("wb_ok_busy", 32'(sbif.Busy), 32'h20);
    tick();
    sbif.WbRegWrite = 1'b0;
    #1;
    chk("wb_ok_sberr", 32'(sbif.SbErr), 32'h0);
    chk("wb_ok_free",  32'(sbif.Busy),  32'h00);

    // Early writeback (cnt=3) sets sticky SbErr
    drive_issue(1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 2'd3);
    tick();
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    sbif.WbRegWrite = 1'b1;
    sbif.WbRDo      = 3'd5;
    tick();
    sbif.WbRegWrite = 1'b0;
    #1;
    chk("wb_bad_sberr", 32'(sbif.SbErr), 32'h1);
    chk("wb_bad_busy",  32'(sbif.Busy),  32'h20);
    tick();
    tick();
    chk("wb_sticky",    32'(sbif.SbErr), 32'h1);
    chk("wb_bad_drain", 32'(sbif.Busy),  32'h00);

    // Flush kills in-flight writes and the concurrent issue
    drive_issue(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 2'd3);
    tick();
    drive_issue(1'b1, 3'd0, 3'd0, 3'd6, 1'b1, 2'd3);
    tick();
    drive_issue(1'b1, 3'd4, 3'd0, 3'd2, 1'b1, 2'd3);
    sbif.Flush = 1'b1;
    #1;
    chk("fl_busy_pre", 32'(sbif.Busy),      32'h50);
    chk("fl_fire",     32'(sbif.IssueFire), 32'h0);
    chk("fl_stall",    32'(sbif.Stall),     32'h0);
    tick();
    sbif.Flush = 1'b0;
    drive_issue(1'b1, 3'd4, 3'd6, 3'd0, 1'b0, 2'd0);
    #1;
    chk("fl_busy_post", 32'(sbif.Busy),      32'h00);
    chk("fl_nostall",   32'(sbif.Stall),     32'h0);
    chk("fl_fire_post", 32'(sbif.IssueFire), 32'h1);
    chk("fl_cnt",       32'(sbif.StallCnt),  32'h01);
    tick();

    // Sustained RAW on R1: fire, then three stalled cycles, repeated
    drive_issue(1'b1, 3'd1, 3'd0, 3'd1, 1'b1, 2'd3);
    #1;
    chk("sat_first_fire", 32'(sbif.IssueFire), 32'h1);
    for (int k = 0; k < 8; k++) tick();
    // 6 stalled cycles so far on top of the earlier 1
    chk("sat_mid_cnt", 32'(sbif.StallCnt), 32'h07);
    for (int k = 0; k < 393; k++) tick();
    chk("sat_stall", 32'(sbif.Stall),    32'h1);
    chk("sat_cnt",   32'(sbif.StallCnt), 32'hFF);
    tick();
    chk("sat_hold",  32'(sbif.StallCnt), 32'hFF);

    // Reset mid-stall
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    #1;
    chk("rst2_cnt",   32'(sbif.StallCnt), 32'h00);
    chk("rst2_busy",  32'(sbif.Busy),     32'h00);
    chk("rst2_sberr", 32'(sbif.SbErr),    32'h0);
    chk("rst2_stall", 32'(sbif.Stall),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
